// File: rtl/fp_uart_dump_if.sv
// fp_uart_dump_if: start/prog/W-bus inputs and address/status/UART outputs of the front-panel dump reader
interface fp_uart_dump_if;
  logic       start;
  logic       prog;
  logic [7:0] bus_data;
  logic [3:0] dump_adr;
  logic       dump_rd;
  logic       busy;
  logic       done;
  logic       tx;
  modport master (output start, prog, bus_data, input dump_adr, dump_rd, busy, done, tx);
  modport slave (input start, prog, bus_data, output dump_adr, dump_rd, busy, done, tx);
endinterface

// File: rtl/fp_uart_dump.sv
// fp_uart_dump: walks RAM 0..15 and sends each byte as "A:DD\r\n" over 8N1 UART; DUMP_CHECKSUM_EN adds an "S:XX\r\n" sum line
module fp_uart_dump #(
  parameter int CLKS_PER_BIT  = 868,
  parameter int SETTLE_CYCLES = 4
) (
  input logic           sysclk,
  input logic           reset_n,
  fp_uart_dump_if.slave bus
);
  localparam int CMAX = CLKS_PER_BIT > SETTLE_CYCLES ? CLKS_PER_BIT : SETTLE_CYCLES;
  localparam int CW = $clog2(CMAX) + 1;
  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    SEND,
    NEXT,
`ifdef DUMP_CHECKSUM_EN
    SUM,
`endif
    DONE
  } state_t;
  state_t state, state_n;
  logic [3:0] adr, adr_n;
  logic [7:0] data, data_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] bit_idx, bit_n;
  logic [2:0] chr, chr_n;
  logic tx, tx_n, done, done_n;
  logic is_sum;
  logic [7:0] val, ch;
  logic [9:0] frame;
  function automatic logic [7:0] hex(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
`ifdef DUMP_CHECKSUM_EN
  logic [7:0] sum, sum_n;
  assign is_sum = state == SUM;
  assign val = is_sum ? sum : data;
`else
  assign is_sum = 1'b0;
  assign val = data;
`endif
  assign bus.dump_adr = adr;
  assign bus.busy = state != IDLE;
  assign bus.dump_rd = state != IDLE;
  assign bus.done = done;
  assign bus.tx = tx;
  // character currently being framed, selected by its position in the line
  always_comb begin
    ch = chr == 3'd0 ? (is_sum ? 8'h53 : hex(adr)) :
         chr == 3'd1 ? 8'h3A :
         chr == 3'd2 ? hex(val[7:4]) :
         chr == 3'd3 ? hex(val[3:0]) :
         chr == 3'd4 ? 8'h0D : 8'h0A;
    frame = {1'b1, ch, 1'b0};
  end
  // sequencer and UART bit timing; tx is registered so reset forces it high at once
  always_comb begin
    state_n = state;
    adr_n = adr;
    data_n = data;
    cnt_n = cnt;
    bit_n = bit_idx;
    chr_n = chr;
    done_n = 1'b0;
    tx_n = 1'b1;
`ifdef DUMP_CHECKSUM_EN
    sum_n = sum;
`endif
    case (state)
      IDLE: if (bus.start && bus.prog) begin
        state_n = SETTLE;
        adr_n = 4'd0;
        cnt_n = '0;
`ifdef DUMP_CHECKSUM_EN
        sum_n = 8'd0;
`endif
      end
      SETTLE: begin
        if (!bus.prog) state_n = IDLE;
        else if (cnt == CW'(SETTLE_CYCLES - 1)) state_n = CAPTURE;
        else cnt_n = cnt + 1'b1;
      end
      CAPTURE: begin
        data_n = bus.bus_data;
`ifdef DUMP_CHECKSUM_EN
        sum_n = sum + bus.bus_data;
`endif
        cnt_n = '0;
        bit_n = 4'd0;
        chr_n = 3'd0;
        state_n = SEND;
      end
`ifdef DUMP_CHECKSUM_EN
      SEND, SUM: begin
`else
      SEND: begin
`endif
        tx_n = frame[bit_idx];
        if (cnt != CW'(CLKS_PER_BIT - 1)) cnt_n = cnt + 1'b1;
        else begin
          cnt_n = '0;
          if (bit_idx != 4'd9) bit_n = bit_idx + 4'd1;
          else begin
            bit_n = 4'd0;
            if (!bus.prog) state_n = IDLE;
            else if (chr != 3'd5) chr_n = chr + 3'd1;
            else state_n = state == SEND ? NEXT : DONE;
          end
        end
      end
      NEXT: begin
        cnt_n = '0;
        bit_n = 4'd0;
        chr_n = 3'd0;
        if (!bus.prog) state_n = IDLE;
`ifdef DUMP_CHECKSUM_EN
        else if (adr == 4'd15) state_n = SUM;
`else
        else if (adr == 4'd15) state_n = DONE;
`endif
        else begin
          adr_n = adr + 4'd1;
          state_n = SETTLE;
        end
      end
      DONE: begin
        done_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      adr <= 4'd0;
      data <= 8'd0;
      cnt <= '0;
      bit_idx <= 4'd0;
      chr <= 3'd0;
      tx <= 1'b1;
      done <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      sum <= 8'd0;
`endif
    end else begin
      state <= state_n;
      adr <= adr_n;
      data <= data_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      chr <= chr_n;
      tx <= tx_n;
      done <= done_n;
`ifdef DUMP_CHECKSUM_EN
      sum <= sum_n;
`endif
    end
  end
endmodule

// File: tb/tb_fp_uart_dump.sv
// tb_fp_uart_dump: RAM model on the W bus, UART receiver on tx, line-level model of the expected dump text
module tb_fp_uart_dump;
  localparam int CPB = 4;
`ifdef DUMP_CHECKSUM_EN
  localparam int N_CHARS = 102;
`else
  localparam int N_CHARS = 96;
`endif
  logic clk, rst_n;
  logic [7:0] ram [16];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int n_cmp = 0, n_bad = 0, done_cnt = 0;
  fp_uart_dump_if bus();
  fp_uart_dump #(.CLKS_PER_BIT(CPB), .SETTLE_CYCLES(2)) dut (.sysclk(clk), .reset_n(rst_n), .bus(bus));
  assign bus.bus_data = ram[bus.dump_adr];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask
  function automatic logic [7:0] hexc(input logic [3:0] n);
    return n < 4'd10 ? 8'd48 + {4'd0, n} : 8'd65 + {4'd0, n} - 8'd10;
  endfunction
  function automatic logic [47:0] line_of(input logic [7:0] q[$], input int ln);
    if (q.size() < 6 * ln + 6) return 48'hFFFF_FFFF_FFFF;
    return {q[6*ln], q[6*ln+1], q[6*ln+2], q[6*ln+3], q[6*ln+4], q[6*ln+5]};
  endfunction
  task automatic build_exp();
    logic [7:0] s;
    s = 8'd0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(hexc(i[3:0]));
      exp_q.push_back(8'd58);
      exp_q.push_back(hexc(ram[i][7:4]));
      exp_q.push_back(hexc(ram[i][3:0]));
      exp_q.push_back(8'd13);
      exp_q.push_back(8'd10);
      s = s + ram[i];
    end
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back(8'd83);
    exp_q.push_back(8'd58);
    exp_q.push_back(hexc(s[7:4]));
    exp_q.push_back(hexc(s[3:0]));
    exp_q.push_back(8'd13);
    exp_q.push_back(8'd10);
`endif
  endtask
  task automatic pulse();
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask
  task automatic begin_dump();
    build_exp();
    rx_q.delete();
    done_cnt = 0;
    pulse();
  endtask
  task automatic finish_dump();
    int t = 0;
    while (bus.busy && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("dump_timeout", 64'(t < 20000), 1);
    repeat (12) @(negedge clk);
    chk("busy_after", bus.busy, 0);
    chk("n_chars", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) chk($sformatf("char%0d", i), rx_q[i], exp_q[i]);
    chk("done_pulses", done_cnt, 1);
  endtask
  // UART receiver plus per-cycle invariants, sampled on the falling edge
  initial begin
    int tick;
    logic [7:0] sh;
    bit in_f;
    in_f = 0;
    tick = 0;
    sh = 8'd0;
    forever begin
      @(negedge clk);
      chk("rd_eq_busy", bus.dump_rd, bus.busy);
      if (!bus.busy) chk("idle_tx", bus.tx, 1);
      if (bus.done) done_cnt++;
      if (!rst_n) in_f = 0;
      else if (!in_f) begin
        if (bus.tx == 1'b0) begin
          in_f = 1;
          tick = 0;
        end
      end else begin
        tick++;
        if (tick == CPB / 2) chk("start_bit", bus.tx, 0);
        else if (tick == CPB / 2 + 9 * CPB) begin
          chk("stop_bit", bus.tx, 1);
          rx_q.push_back(sh);
          in_f = 0;
        end else if (tick > CPB / 2 && (tick - CPB / 2) % CPB == 0) sh = {bus.tx, sh[7:1]};
      end
    end
  end
  initial begin
    bit saw_busy, saw_low;
    int t;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.prog = 1'b1;
    for (int i = 0; i < 16; i++) ram[i] = 8'h10 + 8'(i);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", bus.tx, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rd", bus.dump_rd, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_adr", bus.dump_adr, 0);
    rst_n = 1'b1;
    begin_dump();
    chk("model_len", exp_q.size(), N_CHARS);
    chk("model_line0", line_of(exp_q, 0), 48'h303A31300D0A);
    finish_dump();
    chk("line0", line_of(rx_q, 0), 48'h303A31300D0A);
    chk("lineF", line_of(rx_q, 15), 48'h463A31460D0A);
    ram[3] = 8'hAB;
    ram[12] = 8'h0F;
    begin_dump();
    chk("model_line3", line_of(exp_q, 3), 48'h333A41420D0A);
    finish_dump();
    chk("line3", line_of(rx_q, 3), 48'h333A41420D0A);
    chk("lineC", line_of(rx_q, 12), 48'h433A30460D0A);
    bus.prog = 1'b0;
    rx_q.delete();
    pulse();
    saw_busy = 0;
    saw_low = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.busy) saw_busy = 1;
      if (!bus.tx) saw_low = 1;
    end
    chk("noprog_busy", saw_busy, 0);
    chk("noprog_tx_low", saw_low, 0);
    chk("noprog_chars", rx_q.size(), 0);
    bus.prog = 1'b1;
    begin_dump();
    repeat (48) @(posedge clk);
    pulse();
    repeat (148) @(posedge clk);
    pulse();
    finish_dump();
    begin_dump();
    t = 0;
    while (rx_q.size() < 19 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    while (bus.tx && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("char20_timeout", 64'(t < 20000), 1);
    chk("chars_before_rst", rx_q.size(), 19);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_tx", bus.tx, 1);
    chk("arst_busy", bus.busy, 0);
    chk("arst_adr", bus.dump_adr, 0);
    @(posedge clk);
    #1;
    chk("arst_edge_tx", bus.tx, 1);
    chk("arst_edge_busy", bus.busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    begin_dump();
    finish_dump();
    chk("rst_line0", line_of(rx_q, 0), line_of(exp_q, 0));
    chk("rst_first_adr", rx_q.size() > 0 ? rx_q[0] : 8'h00, 8'h30);
`ifdef DUMP_CHECKSUM_EN
    for (int i = 0; i < 16; i++) ram[i] = 8'hFF;
    begin_dump();
    chk("model_sum_line", line_of(exp_q, 16), 48'h533A46300D0A);
    finish_dump();
    chk("sum_line", line_of(rx_q, 16), 48'h533A46300D0A);
    chk("sum_chars", rx_q.size(), 102);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
